// File: rtl/bus_bridge_master.sv
// Remote-side UART bus bridge: receives {mode, wdata, addr} command frames over UART,
// replays each one as a single initiator transaction and returns read data as one UART byte.

module uart #(
    parameter int TX_DATA_WIDTH    = 8,
    parameter int RX_DATA_WIDTH    = 8,
    parameter int CLOCKS_PER_PULSE = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [TX_DATA_WIDTH-1:0] din,
    input  logic                     en,
    output logic                     tx_busy,
    output logic                     tx,
    input  logic                     rx,
    output logic                     ready,
    output logic [RX_DATA_WIDTH-1:0] dout
);
    localparam int CW  = $clog2(CLOCKS_PER_PULSE + 1);
    localparam int TPW = $clog2(TX_DATA_WIDTH + 2);
    localparam int RIW = $clog2(RX_DATA_WIDTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [TX_DATA_WIDTH-1:0] txShift_q;
    logic [TPW-1:0]           txPhase_q;
    logic [CW-1:0]            txCnt_q;
    logic                     txBusy_q, tx_q;

    // Transmitter: phase 0 is the start bit, phases 1..TX_DATA_WIDTH carry data LSB first, last is stop.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            txShift_q <= '0;
            txPhase_q <= '0;
            txCnt_q   <= '0;
            txBusy_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else if (!txBusy_q) begin
            if (en) begin
                txShift_q <= din;
                txPhase_q <= '0;
                txCnt_q   <= '0;
                txBusy_q  <= 1'b1;
                tx_q      <= 1'b0;
            end
        end else if (txCnt_q == CW'(CLOCKS_PER_PULSE - 1)) begin
            txCnt_q <= '0;
            if (txPhase_q == TPW'(TX_DATA_WIDTH + 1)) begin
                txBusy_q <= 1'b0;
            end else begin
                txPhase_q <= txPhase_q + TPW'(1);
                tx_q      <= (txPhase_q < TPW'(TX_DATA_WIDTH)) ? txShift_q[0] : 1'b1;
                if (txPhase_q < TPW'(TX_DATA_WIDTH))
                    txShift_q <= txShift_q >> 1;
            end
        end else begin
            txCnt_q <= txCnt_q + CW'(1);
        end
    end

    assign tx      = tx_q;
    assign tx_busy = txBusy_q;

    rx_state_t                rxState_q, rxState_d;
    logic [CW-1:0]            rxCnt_q, rxCnt_d;
    logic [RIW-1:0]           rxIdx_q, rxIdx_d;
    logic [RX_DATA_WIDTH-1:0] rxShift_q, rxShift_d, dout_q, dout_d;
    logic                     ready_q, ready_d, rxMeta_q, rxSync_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rxState_q <= RX_IDLE;
            rxCnt_q   <= '0;
            rxIdx_q   <= '0;
            rxShift_q <= '0;
            dout_q    <= '0;
            ready_q   <= 1'b0;
            rxMeta_q  <= 1'b1;
            rxSync_q  <= 1'b1;
        end else begin
            rxState_q <= rxState_d;
            rxCnt_q   <= rxCnt_d;
            rxIdx_q   <= rxIdx_d;
            rxShift_q <= rxShift_d;
            dout_q    <= dout_d;
            ready_q   <= ready_d;
            rxMeta_q  <= rx;
            rxSync_q  <= rxMeta_q;
        end
    end

    // Receiver re-checks the start bit at half a bit time so every later sample lands mid-bit;
    // ready stays high until the next start bit so the consumer can edge-detect it.
    always_comb begin
        rxState_d = rxState_q;
        rxCnt_d   = rxCnt_q;
        rxIdx_d   = rxIdx_q;
        rxShift_d = rxShift_q;
        dout_d    = dout_q;
        ready_d   = ready_q;
        case (rxState_q)
            RX_IDLE: begin
                if (!rxSync_q) begin
                    rxState_d = RX_START;
                    rxCnt_d   = '0;
                    ready_d   = 1'b0;
                end
            end
            RX_START: begin
                if (rxCnt_q == CW'(CLOCKS_PER_PULSE / 2 - 1)) begin
                    rxCnt_d   = '0;
                    rxIdx_d   = '0;
                    rxState_d = rxSync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rxCnt_d = rxCnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rxCnt_q == CW'(CLOCKS_PER_PULSE - 1)) begin
                    rxCnt_d   = '0;
                    rxShift_d = {rxSync_q, rxShift_q[RX_DATA_WIDTH-1:1]};
                    if (rxIdx_q == RIW'(RX_DATA_WIDTH - 1))
                        rxState_d = RX_STOP;
                    else
                        rxIdx_d = rxIdx_q + RIW'(1);
                end else begin
                    rxCnt_d = rxCnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rxCnt_q == CW'(CLOCKS_PER_PULSE - 1)) begin
                    rxCnt_d   = '0;
                    rxState_d = RX_IDLE;
                    if (rxSync_q) begin
                        dout_d  = rxShift_q;
                        ready_d = 1'b1;
                    end
                end else begin
                    rxCnt_d = rxCnt_q + CW'(1);
                end
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    assign ready = ready_q;
    assign dout  = dout_q;
endmodule

module bus_bridge_master #(
    parameter int DATA_WIDTH            = 8,
    parameter int ADDR_WIDTH            = 12,
    parameter int UART_CLOCKS_PER_PULSE = 5208,
    parameter int TIMEOUT_CYCLES        = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  u_rx,
    output logic                  u_tx,
    output logic                  mreq,
    output logic                  mmode,
    output logic [ADDR_WIDTH-1:0] maddr,
    output logic [DATA_WIDTH-1:0] mwdata,
    input  logic                  mack,
    input  logic                  mrvalid,
    input  logic [DATA_WIDTH-1:0] mrdata,
    output logic                  busy,
    output logic                  overflow,
    output logic                  timeout
);
    localparam int FW  = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int CTW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, REQ, RSEND, TXSTART, TXWAIT} state_t;

    state_t                state_q, state_d;
    logic [FW-1:0]         buf_q, buf_d;
    logic                  buf_valid_q, buf_valid_d;
    logic                  ready_q;
    logic [CTW-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, mwdata_q, mwdata_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic                  mreq_q, mreq_d, mmode_q, mmode_d;
    logic                  busy_q, busy_d, overflow_q, overflow_d, timeout_q, timeout_d;

    logic                  u_en, u_tx_busy, u_ready;
    logic [FW-1:0]         u_dout;

    uart #(
        .TX_DATA_WIDTH   (DATA_WIDTH),
        .RX_DATA_WIDTH   (FW),
        .CLOCKS_PER_PULSE(UART_CLOCKS_PER_PULSE)
    ) u_uart (
        .clk    (clk),
        .rstn   (~rst),
        .din    (rdata_q),
        .en     (u_en),
        .tx_busy(u_tx_busy),
        .tx     (u_tx),
        .rx     (u_rx),
        .ready  (u_ready),
        .dout   (u_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            mreq_q      <= 1'b0;
            mmode_q     <= 1'b0;
            maddr_q     <= '0;
            mwdata_q    <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            ready_q     <= u_ready;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            mreq_q      <= mreq_d;
            mmode_q     <= mmode_d;
            maddr_q     <= maddr_d;
            mwdata_q    <= mwdata_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            timeout_q   <= timeout_d;
        end
    end

    // A timed-out read still answers with a zero byte so the remote requester is never left waiting.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mreq_d      = mreq_q;
        mmode_d     = mmode_q;
        maddr_d     = maddr_q;
        mwdata_d    = mwdata_q;
        overflow_d  = overflow_q;
        timeout_d   = 1'b0;
        u_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (buf_valid_q) begin
                    mmode_d     = buf_q[FW-1];
                    maddr_d     = buf_q[ADDR_WIDTH-1:0];
                    mwdata_d    = buf_q[ADDR_WIDTH +: DATA_WIDTH];
                    buf_valid_d = 1'b0;
                    cnt_d       = '0;
                    mreq_d      = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (mmode_q && mack) begin
                    mreq_d  = 1'b0;
                    state_d = IDLE;
                end else if (!mmode_q && mrvalid) begin
                    rdata_d = mrdata;
                    mreq_d  = 1'b0;
                    state_d = RSEND;
                end else if (cnt_q == CTW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    mreq_d    = 1'b0;
                    if (mmode_q) begin
                        state_d = IDLE;
                    end else begin
                        rdata_d = '0;
                        state_d = RSEND;
                    end
                end else begin
                    cnt_d = cnt_q + CTW'(1);
                end
            end
            RSEND: begin
                u_en    = 1'b1;
                state_d = TXSTART;
            end
            TXSTART: if (u_tx_busy) state_d = TXWAIT;
            TXWAIT:  if (!u_tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (u_ready && !ready_q) begin
            if (!buf_valid_q || (state_q == IDLE)) begin
                buf_d       = u_dout;
                buf_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
        busy_d = (state_d != IDLE) || buf_valid_d;
    end

    assign mreq     = mreq_q;
    assign mmode    = mmode_q;
    assign maddr    = maddr_q;
    assign mwdata   = mwdata_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign timeout  = timeout_q;
endmodule

// File: tb/tb_bus_bridge_master.sv
// Bench for bus_bridge_master: drives UART command frames, plays the initiator port and
// decodes returned UART bytes against a queue-based model of the expected transactions.

module tb_bus_bridge_master;
    localparam int DW  = 8;
    localparam int AW  = 12;
    localparam int FW  = DW + AW + 1;
    localparam int CPP = 4;
    localparam int TO  = 256;

    typedef struct {
        logic          mode;
        logic [DW-1:0] wdata;
        logic [AW-1:0] addr;
    } txn_t;

    logic          clk = 1'b0, rst = 1'b1, u_rx = 1'b1;
    logic          mack = 1'b0, mrvalid = 1'b0;
    logic [DW-1:0] mrdata = '0;
    logic          u_tx, mreq, mmode, busy, overflow, timeout;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata;

    int   checks = 0, errors = 0;
    txn_t expQ[$];

    bus_bridge_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .UART_CLOCKS_PER_PULSE(CPP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .u_rx(u_rx), .u_tx(u_tx),
        .mreq(mreq), .mmode(mmode), .maddr(maddr), .mwdata(mwdata),
        .mack(mack), .mrvalid(mrvalid), .mrdata(mrdata),
        .busy(busy), .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Serialises one command frame LSB first, changing u_rx only on falling clock edges.
    task automatic applyStimulus(input logic mode, input logic [DW-1:0] wdata, input logic [AW-1:0] addr,
                                 input bit accepted);
        logic [FW-1:0] f;
        txn_t t;
        f = {mode, wdata, addr};
        t.mode = mode; t.wdata = wdata; t.addr = addr;
        if (accepted) expQ.push_back(t);
        @(negedge clk) u_rx = 1'b0;
        repeat (CPP) @(negedge clk);
        for (int i = 0; i < FW; i++) begin
            u_rx = f[i];
            repeat (CPP) @(negedge clk);
        end
        u_rx = 1'b1;
        repeat (CPP) @(negedge clk);
    endtask

    task automatic waitMreq(input string tag);
        int n = 0;
        while (!mreq && n < 4 * FW * CPP) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_mreq"}, 32'(mreq), 32'd1);
    endtask

    task automatic checkTxn(input string tag);
        txn_t t;
        checkOutput({tag, "_queued"}, 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
            t = expQ.pop_front();
            checkOutput({tag, "_mmode"}, 32'(mmode), 32'(t.mode));
            checkOutput({tag, "_maddr"}, 32'(maddr), 32'(t.addr));
            checkOutput({tag, "_mwdata"}, 32'(mwdata), 32'(t.wdata));
        end
    endtask

    task automatic pulseAck(input logic isRead, input logic [DW-1:0] data);
        if (isRead) begin
            mrvalid = 1'b1;
            mrdata  = data;
        end else begin
            mack = 1'b1;
        end
        @(negedge clk);
        mrvalid = 1'b0;
        mack    = 1'b0;
    endtask

    // Expects a UART byte starting now or soon; samples each bit at its midpoint.
    task automatic recvByte(input string tag, input logic [DW-1:0] exp);
        logic [DW-1:0] b;
        int n = 0;
        b = '0;
        while (u_tx && n < 8 * CPP) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_start"}, 32'(u_tx), 32'd0);
        repeat (CPP + CPP / 2) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            b[i] = u_tx;
            if (i < DW - 1) repeat (CPP) @(negedge clk);
        end
        repeat (CPP) @(negedge clk);
        checkOutput({tag, "_stop"}, 32'(u_tx), 32'd1);
        checkOutput({tag, "_byte"}, 32'(b), 32'(exp));
        repeat (CPP) @(negedge clk);
    endtask

    task automatic countTxLow(input string tag, input int cycles);
        int lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (!u_tx) lows++;
        end
        checkOutput({tag, "_txIdle"}, 32'(lows), 32'd0);
    endtask

    initial begin
        int hi, early;
        logic [DW-1:0] rd;
        logic m;
        logic [DW-1:0] wd;
        logic [AW-1:0] ad;

        repeat (3) @(negedge clk);
        checkOutput("rst_mreq", 32'(mreq), 32'd0);
        checkOutput("rst_fields", 32'({mmode, maddr, mwdata}), 32'd0);
        checkOutput("rst_flags", 32'({busy, overflow, timeout}), 32'd0);
        checkOutput("rst_utx", 32'(u_tx), 32'd1);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] write transaction");
        applyStimulus(1'b1, 8'hA5, 12'h123, 1'b1);
        waitMreq("wr");
        checkOutput("wr_busy", 32'(busy), 32'd1);
        checkTxn("wr");
        repeat (2) @(negedge clk);
        checkOutput("wr_mreqHeld", 32'(mreq), 32'd1);
        pulseAck(1'b0, '0);
        checkOutput("wr_mreqDrop", 32'(mreq), 32'd0);
        checkOutput("wr_busyDone", 32'(busy), 32'd0);
        countTxLow("wr", 12 * CPP);

        $display("[TB] read transaction");
        applyStimulus(1'b0, 8'h00, 12'h7FF, 1'b1);
        waitMreq("rd");
        checkTxn("rd");
        pulseAck(1'b1, 8'h3C);
        checkOutput("rd_mreqDrop", 32'(mreq), 32'd0);
        recvByte("rd", 8'h3C);
        checkOutput("rd_idle", 32'({busy, overflow}), 32'd0);

        $display("[TB] buffering and overflow");
        applyStimulus(1'b0, 8'h00, 12'h011, 1'b1);
        applyStimulus(1'b0, 8'h00, 12'h022, 1'b1);
        checkOutput("ovf_before", 32'(overflow), 32'd0);
        applyStimulus(1'b0, 8'h00, 12'h033, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("ovf_set", 32'(overflow), 32'd1);
        checkOutput("ovf_firstPending", 32'(mreq), 32'd1);
        checkTxn("ovf1");
        pulseAck(1'b1, 8'h5A);
        recvByte("ovf1", 8'h5A);
        waitMreq("ovf2");
        checkTxn("ovf2");
        pulseAck(1'b1, 8'hC3);
        recvByte("ovf2", 8'hC3);
        hi = 0;
        for (int i = 0; i < 4 * FW; i++) begin
            @(negedge clk);
            if (mreq) hi++;
        end
        checkOutput("ovf_thirdDropped", 32'(hi), 32'd0);
        checkOutput("ovf_sticky", 32'({busy, overflow}), 32'b01);

        $display("[TB] read timeout");
        applyStimulus(1'b0, 8'h00, 12'h444, 1'b1);
        waitMreq("to");
        checkTxn("to");
        hi = 0;
        early = 0;
        while (mreq && hi < TO + 8) begin
            hi++;
            if (timeout) early++;
            @(negedge clk);
        end
        checkOutput("to_mreqCycles", 32'(hi), 32'(TO));
        checkOutput("to_noEarlyPulse", 32'(early), 32'd0);
        checkOutput("to_pulse", 32'(timeout), 32'd1);
        @(negedge clk);
        checkOutput("to_pulseOneCycle", 32'(timeout), 32'd0);
        recvByte("to", 8'h00);

        $display("[TB] reset during response");
        applyStimulus(1'b0, 8'h00, 12'h555, 1'b1);
        waitMreq("rr");
        checkTxn("rr");
        pulseAck(1'b1, 8'h81);
        hi = 0;
        while (u_tx && hi < 8 * CPP) begin
            @(negedge clk);
            hi++;
        end
        checkOutput("rr_txStarted", 32'(u_tx), 32'd0);
        repeat (3 * CPP) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rr_mreq", 32'(mreq), 32'd0);
        checkOutput("rr_fields", 32'({mmode, maddr, mwdata}), 32'd0);
        checkOutput("rr_flags", 32'({busy, overflow, timeout}), 32'd0);
        checkOutput("rr_utx", 32'(u_tx), 32'd1);
        countTxLow("rr", 12 * CPP);
        applyStimulus(1'b1, 8'h3E, 12'h0F0, 1'b1);
        waitMreq("rrw");
        checkTxn("rrw");
        pulseAck(1'b0, '0);
        checkOutput("rrw_done", 32'({mreq, busy}), 32'd0);

        $display("[TB] all-ones write, mrvalid ignored for writes");
        applyStimulus(1'b1, 8'hFF, 12'hFFF, 1'b1);
        waitMreq("ones");
        checkTxn("ones");
        pulseAck(1'b1, 8'h77);
        checkOutput("ones_rvalidIgnored", 32'(mreq), 32'd1);
        pulseAck(1'b0, '0);
        checkOutput("ones_done", 32'({mreq, busy, timeout}), 32'd0);
        countTxLow("ones", 12 * CPP);

        $display("[TB] randomized transactions");
        for (int k = 0; k < 6; k++) begin
            m  = 1'($urandom_range(0, 1));
            wd = DW'($urandom);
            ad = AW'($urandom);
            rd = DW'($urandom);
            applyStimulus(m, wd, ad, 1'b1);
            waitMreq("rnd");
            checkTxn("rnd");
            repeat ($urandom_range(0, 5)) @(negedge clk);
            pulseAck(!m, rd);
            checkOutput("rnd_mreqDrop", 32'(mreq), 32'd0);
            if (m) countTxLow("rnd", 12 * CPP);
            else   recvByte("rnd", rd);
        end
        checkOutput("end_queueEmpty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
